// File: rtl/multimode_reg.sv
// multimode_reg: WIDTH-bit register with per-cycle load, masked toggle, shift-left and up-count modes.
module multimode_reg #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             wrap,
  output logic             changed
);
  localparam logic [WIDTH-1:0] one = WIDTH'(1);
  logic [WIDTH-1:0] nxt;
  always_comb begin
    nxt = mode == 2'b00 ? d :
          mode == 2'b01 ? q ^ d :
          mode == 2'b10 ? {q[WIDTH-2:0], sin} : q + one;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      q       <= RESET_VAL;
      sout    <= 1'b0;
      wrap    <= 1'b0;
      changed <= 1'b0;
    end else begin
      wrap    <= en && mode == 2'b11 && &q;
      changed <= en && nxt != q;
      if (en) q <= nxt;
      if (en && mode == 2'b10) sout <= q[WIDTH-1];
    end
  end
endmodule
